// File: rtl/gray_code_counter_if.sv
// Control and count bundle for gray_code_counter; the counter sits on the slave side.
interface gray_code_counter_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8
);
  logic              en;
  logic              up;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  gray_out;
  logic [WIDTH-1:0]  bin_out;
  logic              out_valid;
  logic              tc;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output en, up, load, load_val,
    input  gray_out, bin_out, out_valid, tc, wrap_cnt
  );

  modport slave (
    input  en, up, load, load_val,
    output gray_out, bin_out, out_valid, tc, wrap_cnt
  );
endinterface

// File: rtl/gray_code_counter.sv
// Registered up/down binary counter with a registered Gray copy, wrap pulse and
// saturating wrap-event count. Priority per edge: load > en > hold.
module gray_code_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  gray_code_counter_if.slave cnt
);

  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [WIDTH-1:0]  gray_q, gray_d;
  logic              valid_q, valid_d;
  logic              tc_q, tc_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              wrap_step;

  always_comb begin
    bin_d     = bin_q;
    valid_d   = 1'b0;
    tc_d      = 1'b0;
    wrap_d    = wrap_q;
    wrap_step = 1'b0;
    if (cnt.load) begin
      bin_d   = cnt.load_val;
      valid_d = (cnt.load_val != bin_q);
    end else if (cnt.en) begin
      if (cnt.up) begin
        wrap_step = (bin_q == '1);
        bin_d     = bin_q + WIDTH'(1);
      end else begin
        wrap_step = (bin_q == '0);
        bin_d     = bin_q - WIDTH'(1);
      end
      valid_d = 1'b1;
      tc_d    = wrap_step;
      if (wrap_step && (wrap_q != '1)) begin
        wrap_d = wrap_q + WRAP_W'(1);
      end
    end
    // Gray is encoded from the next binary value so both registers change on one edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      tc_q    <= 1'b0;
      wrap_q  <= '0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cnt.bin_out   = bin_q;
  assign cnt.gray_out  = gray_q;
  assign cnt.out_valid = valid_q;
  assign cnt.tc        = tc_q;
  assign cnt.wrap_cnt  = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: two instances (WRAP_W=8 and WRAP_W=2) share stimulus
// and are checked against directed vectors and a reflected-Gray reference model.
module tb_gray_code_counter;

  logic clk;
  logic rst_n;

  gray_code_counter_if #(.WIDTH(4), .WRAP_W(8)) ifa ();
  gray_code_counter_if #(.WIDTH(4), .WRAP_W(2)) ifb ();

  gray_code_counter #(.WIDTH(4), .WRAP_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .cnt(ifa));
  gray_code_counter #(.WIDTH(4), .WRAP_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .cnt(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ld; int en; int up; int lv;
    int eb; int eg; int ev; int etc;
  } vec_t;

  vec_t tab[$];
  int   up_gray[16] = '{1, 3, 2, 6, 7, 5, 4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 9, 8, 0};
  int   gray_tab[16];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_bin;
  int m_valid;
  int m_tc;
  int m_wraps;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bin = 0; m_valid = 0; m_tc = 0; m_wraps = 0;
  endtask

  task automatic model_step(input bit ld, input bit en, input bit up, input int lv);
    bit wr;
    wr = 1'b0;
    if (ld) begin
      m_valid = (lv != m_bin) ? 1 : 0;
      m_tc    = 0;
      m_bin   = lv;
    end else if (en) begin
      if (up) begin
        wr    = (m_bin + 1 == 16);
        m_bin = (m_bin + 1) % 16;
      end else begin
        wr    = (m_bin == 0);
        m_bin = (m_bin + 15) % 16;
      end
      m_valid = 1;
      m_tc    = wr ? 1 : 0;
      if (wr) m_wraps++;
    end else begin
      m_valid = 0;
      m_tc    = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".bin"},   ifa.bin_out,   m_bin);
    chk({tag, ".gray"},  ifa.gray_out,  gray_tab[m_bin]);
    chk({tag, ".valid"}, ifa.out_valid, m_valid);
    chk({tag, ".tc"},    ifa.tc,        m_tc);
    chk({tag, ".wrap8"}, ifa.wrap_cnt,  (m_wraps > 255) ? 255 : m_wraps);
    chk({tag, ".gray2"}, ifb.gray_out,  gray_tab[m_bin]);
    chk({tag, ".wrap2"}, ifb.wrap_cnt,  (m_wraps > 3) ? 3 : m_wraps);
  endtask

  task automatic drive(input bit ld, input bit en, input bit up, input logic [3:0] lv);
    ifa.load = ld; ifa.en = en; ifa.up = up; ifa.load_val = lv;
    ifb.load = ld; ifb.en = en; ifb.up = up; ifb.load_val = lv;
  endtask

  task automatic step(input string tag, input bit ld, input bit en, input bit up,
                      input logic [3:0] lv);
    logic [3:0] prev_gray;
    prev_gray = ifa.gray_out;
    drive(ld, en, up, lv);
    @(posedge clk);
    #1;
    model_step(ld, en, up, int'(lv));
    check_model(tag);
    if (!ld && en) chk({tag, ".onebit"}, $countones(prev_gray ^ ifa.gray_out), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".bin"},   ifa.bin_out,   0);
    chk({tag, ".gray"},  ifa.gray_out,  0);
    chk({tag, ".valid"}, ifa.out_valid, 0);
    chk({tag, ".tc"},    ifa.tc,        0);
    chk({tag, ".wrap8"}, ifa.wrap_cnt,  0);
    chk({tag, ".wrap2"}, ifb.wrap_cnt,  0);
  endtask

  initial begin
    int n;
    vec_t v;

    // reflected-binary construction of the Gray sequence
    gray_tab[0] = 0;
    gray_tab[1] = 1;
    for (int k = 1; k < 4; k++) begin
      n = 1 << k;
      for (int i = 0; i < n; i++) gray_tab[n + i] = n | gray_tab[n - 1 - i];
    end

    for (int i = 0; i < 16; i++) tab.push_back('{0, 1, 1, 0, (i + 1) % 16, up_gray[i], 1, (i == 15) ? 1 : 0});
    tab.push_back('{0, 1, 0, 0, 'hF, 8, 1, 1});
    tab.push_back('{0, 1, 0, 0, 'hE, 9, 1, 0});
    tab.push_back('{1, 1, 1, 'hA, 'hA, 'hF, 1, 0});
    tab.push_back('{1, 0, 0, 'hA, 'hA, 'hF, 0, 0});
    for (int i = 0; i < 5; i++) tab.push_back('{0, 0, 1, 0, 'hA, 'hF, 0, 0});

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0);
    model_reset();

    // reset held for 3 clocks, then released
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    step("post_reset_hold", 1'b0, 1'b0, 1'b0, 4'h0);

    // directed table: count up/wrap, down/wrap, load priority, hold
    for (int i = 0; i < tab.size(); i++) begin
      v = tab[i];
      step($sformatf("vec%0d", i), v.ld[0], v.en[0], v.up[0], v.lv[3:0]);
      chk($sformatf("vec%0d.tab_bin", i),   ifa.bin_out,   v.eb);
      chk($sformatf("vec%0d.tab_gray", i),  ifa.gray_out,  v.eg);
      chk($sformatf("vec%0d.tab_valid", i), ifa.out_valid, v.ev);
      chk($sformatf("vec%0d.tab_tc", i),    ifa.tc,        v.etc);
    end
    chk("wrap_after_table", ifa.wrap_cnt, 2);

    // asynchronous reset between edges at count 7
    step("pre7_load", 1'b1, 1'b0, 1'b0, 4'h6);
    step("to7", 1'b0, 1'b1, 1'b1, 4'h0);
    chk("count7", ifa.bin_out, 7);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_reset");
    @(posedge clk);
    #1;
    check_zero("async_reset_held");
    rst_n = 1'b1;

    // saturation: 5 full up wraps
    for (int i = 0; i < 80; i++) step($sformatf("sat%0d", i), 1'b0, 1'b1, 1'b1, 4'h0);
    chk("sat_wrap2", ifb.wrap_cnt, 3);
    chk("sat_wrap8", ifa.wrap_cnt, 5);

    // randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 7) == 0), 1'($urandom),
           1'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
